chan_err_sched: RTL and testbench
=================================

CHAN_ERR_SCHED -- requirements
Module: chan_err_sched

Interface
REQ-001 SHALL have parameter PW, default 3, meaning width of the injection phase counter (period 2**PW symbols).
REQ-002 SHALL have parameter FW, default 8, meaning width of the frame-length and word counters.
REQ-003 SHALL have parameter FLUSH, default 16, meaning number of decoder-drain cycles after the last symbol.
REQ-004 SHALL have ports, one per line:
 clk  in  1  single clock; all logic on posedge
 rst  in  1  reset, asynchronous, active-low
 start_i  in  1  single-cycle frame start request
 frame_len_i  in  FW  symbols per frame; 0 means 2**FW
 offset_i  in  PW  phase at which an error burst opens
 burst_i  in  2  burst length in symbols; 0 disables injection
 mask_i  in  2  symbol bits flipped while the burst is open
 sym_valid_i  in  1  encoder output valid
 sym_i  in  2  encoder output symbol
 enc_enable_o  out  1  encoder enable
 sym_valid_o  out  1  decoder enable (registered)
 sym_o  out  2  channel symbol to decoder (registered)
 err_inj_o  out  2  bits flipped in the current sym_o
 busy_o  out  1  high in any state other than IDLE
 done_o  out  1  one-cycle frame-complete pulse
 bad_bit_ct_o  out  FW+2  flipped bits in the frame, saturating
 word_ct_o  out  FW  valid symbols accepted in the frame

Function
REQ-005 SHALL implement FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-006 In IDLE, start_i=1 SHALL latch frame_len_i, offset_i, burst_i and mask_i, clear word_ct, bad_bit_ct, phase and burst counters, and move to RUN; start_i outside IDLE SHALL be ignored.
REQ-007 enc_enable_o SHALL be 1 only in RUN.
REQ-008 In RUN, each cycle with sym_valid_i=1 SHALL be one accepted symbol: word_ct and phase increment by 1, and phase wraps at 2**PW.
REQ-009 RUN SHALL move to FLUSH on the cycle the accepted symbol makes word_ct equal to the latched length, where length 0 means 2**FW and word_ct wraps to 0.
REQ-010 An accepted symbol whose phase equals offset SHALL open a burst with burst_left=burst; each accepted symbol while burst_left>0 is corrupted and decrements burst_left.
REQ-011 A burst reopening on an offset match while already open SHALL reload burst_left to burst and SHALL NOT accumulate.
REQ-012 With burst=0, no symbol SHALL be corrupted.
REQ-013 Latency SHALL be 1 cycle: sym_o <= sym_i XOR (corrupt ? mask : 00), err_inj_o <= (corrupt ? mask : 00), and sym_valid_o <= sym_valid_i AND (state==RUN).
REQ-014 sym_valid_i outside RUN SHALL be dropped, giving sym_valid_o=0 and err_inj_o=00.
REQ-015 bad_bit_ct SHALL add popcount(err_inj) on each cycle where sym_valid_i and corrupt are both 1, and SHALL saturate at all-ones.
REQ-016 FLUSH SHALL hold for exactly FLUSH cycles, then go to DONE.
REQ-017 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-018 Counters SHALL hold their values in IDLE until the next start.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE and set every output, counter and latched configuration to 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no done_o pulse.
REQ-021 Operation SHALL resume on the first clk edge after rst returns to 1.

Structure
REQ-022 A shared package chan_pkg SHALL hold the state enum (IDLE, RUN, FLUSH, DONE) and the default PW, FW and FLUSH constants.
REQ-023 One sub-module, inj_window, SHALL hold the phase counter, offset compare and burst_left logic, and output corrupt.

Verification
REQ-024 Stimulus: frame_len=8, burst=0, sym_valid_i always 1. Required: sym_o equals sym_i delayed one cycle, bad_bit_ct_o=0, done_o pulses 8+FLUSH+1 cycles after RUN entry.
REQ-025 Stimulus: offset=1, burst=1, mask=10, frame_len=16. Required: symbols 1 and 9 have bit1 flipped, err_inj_o=10 on each, bad_bit_ct_o=2.
REQ-026 Stimulus: offset=7, burst=2, mask=11, frame_len=16. Required: bursts wrap across phase 7->0, corrupting symbols 7, 8, 15 and the first symbol after the frame is not corrupted; bad_bit_ct_o=6.
REQ-027 Stimulus: frame_len=0, with sym_valid_i gaps every 3rd cycle. Required: exactly 256 symbols accepted, word_ct_o wraps to 0, done_o follows.
REQ-028 Stimulus: start_i during RUN, then rst=0 at symbol 5. Required: the second start is ignored; after reset all outputs are 0, state is IDLE, and no done_o is seen.

Source files
------------

// File: rtl/chan_pkg.sv
// chan_pkg: shared state encoding and default sizing for the channel error scheduler
package chan_pkg;
  localparam int PW_D = 3;
  localparam int FW_D = 8;
  localparam int FLUSH_D = 16;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/inj_window.sv
// inj_window: phase counter, offset match and burst window that flags symbols to corrupt
module inj_window import chan_pkg::*; #(
  parameter int PW = PW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          adv,
  input  logic [PW-1:0] offset,
  input  logic [1:0]    burst,
  output logic          corrupt
);
  logic [PW-1:0] phase;
  logic [1:0]    left;
  logic          hit;
  assign hit = phase == offset;
  assign corrupt = hit ? burst != 2'd0 : left != 2'd0;
  // an offset match reloads the window rather than extending it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
      left  <= '0;
    end else if (clear) begin
      phase <= '0;
      left  <= '0;
    end else if (adv) begin
      phase <= phase + 1'b1;
      left  <= corrupt ? (hit ? burst : left) - 2'd1 : 2'd0;
    end
  end
endmodule

// File: rtl/chan_err_sched.sv
// chan_err_sched: frames encoder symbols through a burst-error channel and drains the decoder
module chan_err_sched import chan_pkg::*; #(
  parameter int PW = PW_D,
  parameter int FW = FW_D,
  parameter int FLUSH = FLUSH_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [FW-1:0] frame_len_i,
  input  logic [PW-1:0] offset_i,
  input  logic [1:0]    burst_i,
  input  logic [1:0]    mask_i,
  input  logic          sym_valid_i,
  input  logic [1:0]    sym_i,
  output logic          enc_enable_o,
  output logic          sym_valid_o,
  output logic [1:0]    sym_o,
  output logic [1:0]    err_inj_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [FW+1:0] bad_bit_ct_o,
  output logic [FW-1:0] word_ct_o
);
  localparam int CW = $clog2(FLUSH + 1);
  state_t        state, state_nx;
  logic [FW-1:0] len_q;
  logic [PW-1:0] off_q;
  logic [1:0]    burst_q, mask_q, inj;
  logic [CW-1:0] fl_ct;
  logic          go, acc, last, corrupt;
  logic [FW+2:0] bad_sum;
  assign go = state == IDLE && start_i;
  assign acc = state == RUN && sym_valid_i;
  assign inj = acc && corrupt ? mask_q : 2'b00;
  // length 0 selects 2**FW: the FW-bit increment wraps to 0 and matches
  assign last = acc && word_ct_o + 1'b1 == len_q;
  assign bad_sum = {1'b0, bad_bit_ct_o} + {{(FW + 1){1'b0}}, inj[1] & inj[0], inj[1] ^ inj[0]};
  assign enc_enable_o = state == RUN;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  inj_window #(.PW(PW)) u_win (
    .clk(clk),
    .rst(rst),
    .clear(go),
    .adv(acc),
    .offset(off_q),
    .burst(burst_q),
    .corrupt(corrupt)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start_i ? RUN : IDLE)
             : state == RUN ? (last ? chan_pkg::FLUSH : RUN)
             : state == chan_pkg::FLUSH ? (fl_ct == CW'(FLUSH - 1) ? DONE : chan_pkg::FLUSH)
             : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len_q        <= '0;
      off_q        <= '0;
      burst_q      <= '0;
      mask_q       <= '0;
      fl_ct        <= '0;
      word_ct_o    <= '0;
      bad_bit_ct_o <= '0;
      sym_valid_o  <= 1'b0;
      sym_o        <= '0;
      err_inj_o    <= '0;
    end else begin
      state       <= state_nx;
      fl_ct       <= state == chan_pkg::FLUSH ? fl_ct + 1'b1 : '0;
      sym_valid_o <= acc;
      sym_o       <= sym_i ^ inj;
      err_inj_o   <= inj;
      if (go) begin
        len_q        <= frame_len_i;
        off_q        <= offset_i;
        burst_q      <= burst_i;
        mask_q       <= mask_i;
        word_ct_o    <= '0;
        bad_bit_ct_o <= '0;
      end else if (acc) begin
        word_ct_o    <= word_ct_o + 1'b1;
        bad_bit_ct_o <= bad_sum[FW+2] ? '1 : bad_sum[FW+1:0];
      end
    end
  end
endmodule

// File: tb/tb_chan_err_sched.sv
// tb_chan_err_sched: scoreboard bench for the channel error scheduler
module tb_chan_err_sched;
  localparam int PW = 3;
  localparam int FW = 8;
  localparam int FLUSH = 16;
  typedef struct {logic [1:0] s; logic [1:0] e;} exp_t;
  logic          clk = 0, rst = 0, start_i = 0, sym_valid_i = 0;
  logic [FW-1:0] frame_len_i = '0;
  logic [PW-1:0] offset_i = '0;
  logic [1:0]    burst_i = '0, mask_i = '0, sym_i = '0;
  logic          enc_enable_o, sym_valid_o, busy_o, done_o;
  logic [1:0]    sym_o, err_inj_o;
  logic [FW+1:0] bad_bit_ct_o;
  logic [FW-1:0] word_ct_o;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  chan_err_sched #(.PW(PW), .FW(FW), .FLUSH(FLUSH)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .frame_len_i(frame_len_i),
    .offset_i(offset_i),
    .burst_i(burst_i),
    .mask_i(mask_i),
    .sym_valid_i(sym_valid_i),
    .sym_i(sym_i),
    .enc_enable_o(enc_enable_o),
    .sym_valid_o(sym_valid_o),
    .sym_o(sym_o),
    .err_inj_o(err_inj_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .bad_bit_ct_o(bad_bit_ct_o),
    .word_ct_o(word_ct_o)
  );
  // drives one frame, scoreboards every output symbol, returns edges from start to done
  task automatic run_frame(input int len, input int off, input int burst, input int mask,
                           input bit gaps, output int edges, output int pops);
    int len_eff, k, bad, cyc;
    bit got, v, c;
    logic [1:0] s, inj;
    exp_t e;
    len_eff = len == 0 ? 256 : len;
    k = 0; bad = 0; cyc = 0; got = 0; pops = 0;
    q.delete();
    @(negedge clk);
    frame_len_i = len[FW-1:0]; offset_i = off[PW-1:0]; burst_i = burst[1:0]; mask_i = mask[1:0];
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    edges = 1;
    while (edges < 2000) begin
      if (done_o === 1'b1) begin
        got = 1;
        break;
      end
      n_cmp++;
      if (sym_valid_o === 1'b1) begin
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_sym: sym_valid_o=1 with nothing expected at edge %0d", edges);
        end else begin
          e = q.pop_front();
          pops++;
          if ({sym_o, err_inj_o} !== {e.s, e.e}) begin
            n_bad++;
            $display("FAIL sym_out #%0d: got sym=%b inj=%b, expected sym=%b inj=%b", pops - 1, sym_o, err_inj_o, e.s, e.e);
          end
        end
      end else if (sym_valid_o !== 1'b0 || err_inj_o !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_out: sym_valid_o=%b err_inj_o=%b, expected 0/00", sym_valid_o, err_inj_o);
      end
      v = gaps ? (cyc % 3 != 2) : 1'b1;
      s = 2'($urandom_range(0, 3));
      sym_valid_i = v;
      sym_i = s;
      if (v && k < len_eff) begin
        c = 0;
        for (int j = 0; j < burst; j++)
          if (k - j >= 0 && (k - j) % 8 == off) c = 1;
        inj = c ? mask[1:0] : 2'b00;
        e.s = s ^ inj;
        e.e = inj;
        q.push_back(e);
        bad += int'(inj[0]) + int'(inj[1]);
        k++;
      end
      cyc++;
      @(negedge clk);
      edges++;
    end
    sym_valid_i = 0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles", edges);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected symbols never appeared", q.size());
    end
    n_cmp++;
    if (word_ct_o !== len[FW-1:0]) begin
      n_bad++;
      $display("FAIL word_ct: got %0d, expected %0d", word_ct_o, len[FW-1:0]);
    end
    n_cmp++;
    if (bad_bit_ct_o !== (FW+2)'(bad)) begin
      n_bad++;
      $display("FAIL bad_bit_ct_model: got %0d, expected %0d", bad_bit_ct_o, bad);
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: done_o=%b busy_o=%b one cycle later, expected 0/0", done_o, busy_o);
    end
  endtask
  task automatic test_reset();
    rst = 0;
    sym_valid_i = 1; sym_i = 2'b11; start_i = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({enc_enable_o, sym_valid_o, sym_o, err_inj_o, busy_o, done_o} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, expected 00000000", {enc_enable_o, sym_valid_o, sym_o, err_inj_o, busy_o, done_o});
    end
    n_cmp++;
    if (bad_bit_ct_o !== '0 || word_ct_o !== '0) begin
      n_bad++;
      $display("FAIL reset_ct: bad=%0d word=%0d, expected 0/0", bad_bit_ct_o, word_ct_o);
    end
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if (sym_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_drop: sym_valid_o=%b busy_o=%b in IDLE, expected 0/0", sym_valid_o, busy_o);
    end
    sym_valid_i = 0;
  endtask
  task automatic test_clean();
    int edges, pops;
    run_frame(8, 0, 0, 3, 0, edges, pops);
    n_cmp++;
    if (edges !== 8 + FLUSH + 1) begin
      n_bad++;
      $display("FAIL clean_latency: done after %0d cycles, expected %0d", edges, 8 + FLUSH + 1);
    end
    n_cmp++;
    if (bad_bit_ct_o !== '0) begin
      n_bad++;
      $display("FAIL clean_bad: got %0d, expected 0", bad_bit_ct_o);
    end
  endtask
  task automatic test_single_burst();
    int edges, pops;
    run_frame(16, 1, 1, 2, 0, edges, pops);
    n_cmp++;
    if (bad_bit_ct_o !== 10'd2) begin
      n_bad++;
      $display("FAIL single_bad: got %0d, expected 2", bad_bit_ct_o);
    end
  endtask
  task automatic test_back_to_back();
    int edges, pops;
    for (int r = 0; r < 2; r++) begin
      run_frame(16, 7, 2, 3, 0, edges, pops);
      n_cmp++;
      if (bad_bit_ct_o !== 10'd6) begin
        n_bad++;
        $display("FAIL wrap_bad run %0d: got %0d, expected 6", r, bad_bit_ct_o);
      end
    end
  endtask
  task automatic test_full_frame();
    int edges, pops;
    run_frame(0, 3, 3, 1, 1, edges, pops);
    n_cmp++;
    if (pops !== 256) begin
      n_bad++;
      $display("FAIL full_count: got %0d symbols, expected 256", pops);
    end
    n_cmp++;
    if (bad_bit_ct_o !== 10'd96) begin
      n_bad++;
      $display("FAIL full_bad: got %0d, expected 96", bad_bit_ct_o);
    end
  endtask
  task automatic test_start_ignored_and_reset();
    logic [1:0] s;
    bit seen;
    @(negedge clk);
    frame_len_i = 16; offset_i = 0; burst_i = 0; mask_i = 0; start_i = 1;
    @(negedge clk);
    start_i = 0;
    for (int k = 0; k < 5; k++) begin
      s = 2'($urandom_range(0, 3));
      sym_valid_i = 1; sym_i = s;
      if (k == 2) begin
        start_i = 1; frame_len_i = 4; burst_i = 3; mask_i = 3;
      end
      @(negedge clk);
      start_i = 0;
      n_cmp++;
      if (sym_valid_o !== 1'b1 || sym_o !== s || err_inj_o !== 2'b00) begin
        n_bad++;
        $display("FAIL restart_sym %0d: valid=%b sym=%b inj=%b, expected 1/%b/00", k, sym_valid_o, sym_o, err_inj_o, s);
      end
    end
    n_cmp++;
    if (word_ct_o !== 8'd5 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_ct: word=%0d busy=%b, expected 5/1", word_ct_o, busy_o);
    end
    #2 rst = 0;
    #1;
    n_cmp++;
    if ({enc_enable_o, sym_valid_o, sym_o, err_inj_o, busy_o, done_o, bad_bit_ct_o, word_ct_o} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs: en=%b v=%b sym=%b inj=%b busy=%b done=%b bad=%0d word=%0d, expected all 0",
               enc_enable_o, sym_valid_o, sym_o, err_inj_o, busy_o, done_o, bad_bit_ct_o, word_ct_o);
    end
    @(negedge clk);
    rst = 1;
    sym_valid_i = 0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_done: done_o or busy_o rose after abort, expected neither");
    end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_single_burst();
    test_back_to_back();
    test_full_frame();
    test_start_ignored_and_reset();
    test_single_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
